// File: rtl/master_arb_if.sv
// Bus-side arbitration front end for one master: requests the shared bus, holds it
// while the core transfers, survives split suspensions and gives up on timeouts.
module master_arb_if #(
  parameter int REQ_TIMEOUT   = 255,
  parameter int SPLIT_TIMEOUT = 1023,
  parameter int CNT_W         = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic       tx_done,
  input  logic       m_grant,
  input  logic       bus_util,
  output logic       m_req,
  output logic       bus_hold,
  output logic       bus_ok,
  output logic       tx_complete,
  output logic       tx_error,
  output logic       split_active,
  output logic [2:0] state
);

  // Handshake with the core: tx_start and tx_done are single-cycle strobes sampled on
  // the rising edge; bus_ok is a level that stays high only while this master owns the bus.

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_TAKE    = 3'd2,
    S_OWN     = 3'd3,
    S_SPLIT   = 3'd4,
    S_RELEASE = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] REQ_LIM   = CNT_W'(REQ_TIMEOUT);
  localparam logic [CNT_W-1:0] SPLIT_LIM = CNT_W'(SPLIT_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             err_d;

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tx_start) state_d = S_REQ;
      end
      S_REQ: begin
        if (m_grant) begin
          state_d = S_TAKE;
        end else if (cnt_q == REQ_LIM) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_TAKE: begin
        state_d = S_OWN;
      end
      S_OWN: begin
        if (tx_done)       state_d = S_RELEASE;
        else if (!m_grant) state_d = S_SPLIT;
      end
      S_SPLIT: begin
        if (m_grant && bus_util) begin
          state_d = S_TAKE;
        end else if (cnt_q == SPLIT_LIM) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_RELEASE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are decoded from the next state and registered, so they line up with
  // the state they describe without any input-to-output combinational path.
  // bus_ok additionally needs the grant seen at the same edge that enters OWN.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_req        <= 1'b0;
      bus_hold     <= 1'b0;
      bus_ok       <= 1'b0;
      tx_complete  <= 1'b0;
      tx_error     <= 1'b0;
      split_active <= 1'b0;
    end else begin
      m_req        <= (state_d == S_REQ) || (state_d == S_TAKE) ||
                      (state_d == S_OWN) || (state_d == S_SPLIT);
      bus_hold     <= (state_d == S_TAKE) || (state_d == S_OWN);
      bus_ok       <= (state_d == S_OWN) && m_grant;
      tx_complete  <= (state_d == S_RELEASE);
      tx_error     <= err_d;
      split_active <= (state_d == S_SPLIT);
    end
  end

  assign state = state_q;

  a_one_outcome: assert property (@(posedge clk) disable iff (rst)
    !(tx_complete && tx_error));
  a_ok_implies_hold: assert property (@(posedge clk) disable iff (rst)
    bus_ok |-> (bus_hold && $past(m_grant)));

endmodule

// File: tb/tb_master_arb_if.sv
// Randomized and directed bench for master_arb_if: a transaction-level reference
// model predicts every cycle's outputs into a queue that a negedge monitor drains.
module tb_master_arb_if;

  localparam int REQ_T   = 4;
  localparam int SPLIT_T = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_start = 1'b0;
  logic       tx_done = 1'b0;
  logic       m_grant = 1'b0;
  logic       bus_util = 1'b1;
  logic       m_req, bus_hold, bus_ok, tx_complete, tx_error, split_active;
  logic [2:0] state;

  int tests = 0;
  int fails = 0;
  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  master_arb_if #(.REQ_TIMEOUT(REQ_T), .SPLIT_TIMEOUT(SPLIT_T), .CNT_W(10)) dut (
    .clk(clk), .rst(rst), .tx_start(tx_start), .tx_done(tx_done),
    .m_grant(m_grant), .bus_util(bus_util), .m_req(m_req), .bus_hold(bus_hold),
    .bus_ok(bus_ok), .tx_complete(tx_complete), .tx_error(tx_error),
    .split_active(split_active), .state(state)
  );

  // Reference model: phase of the current transaction and how long it has waited.
  typedef enum {P_IDLE, P_WAIT, P_CLAIM, P_DRIVE, P_SUSP, P_DONE} phase_t;
  phase_t ph = P_IDLE;
  int     waited = 0;

  always @(posedge clk) begin : model
    phase_t     nx;
    logic       err;
    logic [2:0] code;
    logic [8:0] e;
    nx  = ph;
    err = 1'b0;
    if (rst) begin
      nx = P_IDLE;
    end else begin
      case (ph)
        P_IDLE:  if (tx_start) nx = P_WAIT;
        P_WAIT:  if (m_grant) nx = P_CLAIM;
                 else if (waited >= REQ_T) begin nx = P_IDLE; err = 1'b1; end
                 else waited = waited + 1;
        P_CLAIM: nx = P_DRIVE;
        P_DRIVE: if (tx_done) nx = P_DONE;
                 else if (!m_grant) nx = P_SUSP;
        P_SUSP:  if (m_grant && bus_util) nx = P_CLAIM;
                 else if (waited >= SPLIT_T) begin nx = P_IDLE; err = 1'b1; end
                 else waited = waited + 1;
        default: nx = P_IDLE;
      endcase
    end
    if (nx != ph || rst) waited = 0;
    case (nx)
      P_WAIT:  code = 3'd1;
      P_CLAIM: code = 3'd2;
      P_DRIVE: code = 3'd3;
      P_SUSP:  code = 3'd4;
      P_DONE:  code = 3'd5;
      default: code = 3'd0;
    endcase
    if (rst) e = 9'd0;
    else e = {(nx == P_WAIT || nx == P_CLAIM || nx == P_DRIVE || nx == P_SUSP),
              (nx == P_CLAIM || nx == P_DRIVE),
              (nx == P_DRIVE && m_grant),
              (nx == P_DONE), err, (nx == P_SUSP), code};
    exp_q.push_back(e);
    ph = nx;
  end

  // Monitor: order is {m_req, bus_hold, bus_ok, tx_complete, tx_error, split_active, state}.
  always @(negedge clk) begin : monitor
    logic [8:0] e;
    logic [8:0] act;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      act = {m_req, bus_hold, bus_ok, tx_complete, tx_error, split_active, state};
      tests++;
      if (act !== e) begin
        fails++;
        $display("FAIL scoreboard t=%0t got %b expected %b", $time, act, e);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s t=%0t got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic cyc(input logic s, input logic d, input logic g, input logic u,
                     input logic r = 1'b0);
    tx_start = s;
    tx_done  = d;
    m_grant  = g;
    bus_util = u;
    rst      = r;
    @(posedge clk);
    #1;
  endtask

  task automatic to_own();
    cyc(1, 0, 0, 1);
    cyc(0, 0, 1, 1);
    cyc(0, 0, 1, 1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog simulation did not terminate");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic g;
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 1, 1);
    chk("reset_state", int'(state), 0);
    chk("reset_mreq", int'(m_req), 0);

    // Normal transaction: start @0, grant @3, done @9.
    cyc(1, 0, 0, 1);
    chk("norm_mreq", int'(m_req), 1);
    chk("norm_state_req", int'(state), 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 1, 1);
    chk("norm_hold", int'(bus_hold), 1);
    chk("norm_ok_early", int'(bus_ok), 0);
    cyc(0, 0, 1, 1);
    chk("norm_ok", int'(bus_ok), 1);
    chk("norm_state_own", int'(state), 3);
    repeat (4) cyc(0, 0, 1, 1);
    cyc(0, 1, 1, 1);
    chk("norm_complete", int'(tx_complete), 1);
    chk("norm_mreq_low", int'(m_req), 0);
    cyc(0, 0, 0, 1);
    chk("norm_idle", int'(state), 0);
    chk("norm_complete_pulse", int'(tx_complete), 0);

    // Request timeout.
    cyc(1, 0, 0, 1);
    repeat (REQ_T) cyc(0, 0, 0, 1);
    chk("rto_still_req", int'(state), 1);
    cyc(0, 0, 0, 1);
    chk("rto_error", int'(tx_error), 1);
    chk("rto_mreq", int'(m_req), 0);
    chk("rto_idle", int'(state), 0);
    cyc(0, 0, 0, 1);
    chk("rto_error_pulse", int'(tx_error), 0);

    // Grant on the timeout cycle, then done with grant falling together.
    cyc(1, 0, 0, 1);
    repeat (REQ_T) cyc(0, 0, 0, 1);
    cyc(0, 0, 1, 1);
    chk("gto_take", int'(state), 2);
    chk("gto_no_error", int'(tx_error), 0);
    cyc(0, 0, 1, 1);
    cyc(0, 1, 0, 1);
    chk("sim_release", int'(state), 5);
    chk("sim_complete", int'(tx_complete), 1);
    chk("sim_no_split", int'(split_active), 0);
    cyc(0, 0, 0, 1);

    // Split and resume.
    to_own();
    cyc(0, 0, 0, 1);
    chk("split_active", int'(split_active), 1);
    chk("split_hold", int'(bus_hold), 0);
    repeat (3) cyc(0, 0, 1, 0);
    chk("split_bus_busy", int'(state), 4);
    cyc(0, 0, 1, 1);
    chk("resume_take", int'(state), 2);
    cyc(0, 0, 1, 1);
    chk("resume_ok", int'(bus_ok), 1);
    cyc(0, 1, 1, 1);
    chk("resume_complete", int'(tx_complete), 1);
    cyc(0, 0, 0, 1);

    // Split timeout.
    to_own();
    cyc(0, 0, 0, 1);
    repeat (SPLIT_T) cyc(0, 0, 0, 1);
    chk("sto_still_split", int'(state), 4);
    cyc(0, 0, 0, 1);
    chk("sto_error", int'(tx_error), 1);
    chk("sto_idle", int'(state), 0);
    cyc(0, 0, 0, 1);
    chk("sto_quiet", int'({m_req, bus_hold, bus_ok, tx_error}), 0);

    // Reset while owning the bus, with tx_start asserted during reset.
    to_own();
    cyc(1, 0, 1, 1, 1);
    chk("rst_own_outs", int'({m_req, bus_hold, bus_ok}), 0);
    chk("rst_own_state", int'(state), 0);
    cyc(0, 0, 1, 1);
    chk("rst_start_ignored", int'(state), 0);
    cyc(1, 0, 0, 1);
    chk("rst_first_start", int'(state), 1);
    repeat (REQ_T + 2) cyc(0, 0, 0, 1);

    // Random traffic from a loosely behaved core and bus controller.
    g = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) g = ~g;
      cyc(($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0), g,
          ($urandom_range(0, 9) < 7), ($urandom_range(0, 199) == 0));
    end

    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 1);
    @(negedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/master_arb_if.md
MASTER_ARB_IF -- requirements
Module: master_arb_if

Interface
REQ-001 Parameter REQ_TIMEOUT, default 255: maximum cycles spent in REQ before the request is abandoned.
REQ-002 Parameter SPLIT_TIMEOUT, default 1023: maximum cycles spent in SPLIT before the transaction is abandoned.
REQ-003 Parameter CNT_W, default 10: wait-counter width; both timeouts SHALL be < 2^CNT_W.
REQ-004 clk  in  1  single clock; all logic on the rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 tx_start  in  1  one-cycle pulse from the master core requesting one bus transaction.
REQ-007 tx_done  in  1  one-cycle pulse from the master core: serial transfer finished, bus may be released.
REQ-008 m_grant  in  1  this master's grant line from the bus controller.
REQ-009 bus_util  in  1  shared bus-free line; 1 = free, 0 = held by some master.
REQ-010 m_req  out  1  this master's request line to the bus controller.
REQ-011 bus_hold  out  1  1 = pull bus_util low (this master owns the bus).
REQ-012 bus_ok  out  1  1 = master core may drive the bus.
REQ-013 tx_complete  out  1  one-cycle pulse: transaction finished normally.
REQ-014 tx_error  out  1  one-cycle pulse: transaction abandoned on timeout.
REQ-015 split_active  out  1  1 while the transaction is suspended by a split.
REQ-016 state  out  3  current state encoding (debug).

Function
REQ-017 Encoding: IDLE=0, REQ=1, TAKE=2, OWN=3, SPLIT=4, RELEASE=5; values 6-7 SHALL go to IDLE next cycle.
REQ-018 IDLE: all outputs 0; tx_start=1 -> REQ, wait counter cleared; tx_start in any other state SHALL be ignored.
REQ-019 REQ: m_req=1; m_grant=1 -> TAKE; else counter increments; counter==REQ_TIMEOUT with m_grant=0 -> IDLE, tx_error pulsed on that transition, m_req 0 next cycle.
REQ-020 REQ: m_grant=1 in the same cycle the timeout is reached -> grant wins, TAKE.
REQ-021 TAKE: m_req=1, bus_hold=1, bus_ok=0; exactly one cycle, then OWN (gives the controller one cycle to see bus_util fall).
REQ-022 OWN: m_req=1, bus_hold=1, bus_ok=1; tx_done=1 -> RELEASE; else m_grant=0 -> SPLIT, counter cleared.
REQ-023 OWN: tx_done and m_grant falling in the same cycle -> tx_done wins, RELEASE.
REQ-024 SPLIT: m_req=1, bus_hold=0, bus_ok=0, split_active=1; counter increments each cycle.
REQ-025 SPLIT: m_grant=1 and bus_util=1 (bus free) -> TAKE (resume, no new tx_start needed); m_grant=1 with bus_util=0 -> remain, counter continues.
REQ-026 SPLIT: counter==SPLIT_TIMEOUT without resume -> IDLE, tx_error pulsed on that transition.
REQ-027 RELEASE: m_req=0, bus_hold=0, bus_ok=0, tx_complete=1 for exactly this cycle; then IDLE.
REQ-028 Latency: tx_start to m_req = 1 cycle; m_grant to bus_hold = 1 cycle; m_grant to bus_ok = 2 cycles; tx_done to bus_hold low = 1 cycle.
REQ-029 Counter SHALL saturate, never wrap; it is cleared on every state change.
REQ-030 tx_complete and tx_error SHALL never be asserted in the same cycle; at most one per transaction.
REQ-031 bus_ok=1 SHALL imply bus_hold=1 and m_grant was 1 in the previous cycle.
REQ-032 All outputs SHALL be registered (no combinational path from any input to any output).

Reset
REQ-033 rst=1 at a clock edge -> state IDLE, counter 0, all outputs 0 the following cycle, from any state including OWN and SPLIT.
REQ-034 Inputs SHALL be ignored while rst=1; the first tx_start is accepted the cycle after rst deasserts.

Verification
REQ-035 Normal: tx_start @0, m_grant=1 @3 -> m_req=1 @1, bus_hold=1 @4, bus_ok=1 @5; tx_done @9 -> tx_complete=1 and m_req=0 @10, state IDLE @11.
REQ-036 Request timeout: REQ_TIMEOUT=4, tx_start, m_grant held 0 -> tx_error single pulse on exit from REQ, m_req=0, state IDLE, no bus_hold ever.
REQ-037 Split/resume: in OWN, drop m_grant -> split_active=1, bus_hold=0 next cycle; re-assert m_grant with bus_util=0 for 3 cycles then 1 -> TAKE then OWN, bus_ok=1 again, tx_complete after tx_done.
REQ-038 Split timeout: SPLIT_TIMEOUT=8, no re-grant -> tx_error pulse on exit from SPLIT, all outputs 0 thereafter.
REQ-039 Simultaneous: tx_done and m_grant falling same cycle -> RELEASE, tx_complete=1, split_active stays 0; grant on timeout cycle -> TAKE, no tx_error.
REQ-040 Reset mid-operation: rst=1 while in OWN -> next cycle m_req=bus_hold=bus_ok=0, state=0; tx_start during rst ignored.
